// File: rtl/rc4_phase_ctrl.sv
// Key-search sequencer for an RC4 cracker: walks keys from KEY_START to KEY_MAX,
// launching init/shuffle/decrypt phases in turn and arbitrating the shared S-memory port.
module rc4_phase_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        init_fin,
    input  logic        shuffle_fin,
    input  logic        decrypt_fin,
    input  logic        decrypt_pass,
    output logic        init_start,
    output logic        shuffle_start,
    output logic        decrypt_start,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  shuffle_addr,
    input  logic [7:0]  decrypt_addr,
    input  logic [7:0]  init_data,
    input  logic [7:0]  shuffle_data,
    input  logic [7:0]  decrypt_data,
    input  logic        init_wren,
    input  logic        shuffle_wren,
    input  logic        decrypt_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_data,
    output logic        s_wren,
    output logic [23:0] key,
    output logic        done,
    output logic        found,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT, DEC_GO, DEC_WAIT, NEXT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] key_q, key_d;
    logic        pass_q, pass_d;
    logic        found_q, found_d;
    logic        init_start_q, shuffle_start_q, decrypt_start_q;
    logic        done_q, busy_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pass_d  = pass_q;
        found_d = found_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT_GO;
                    key_d   = KEY_START;
                end
            end
            INIT_GO:   state_d = INIT_WAIT;
            INIT_WAIT: if (init_fin) state_d = SHUF_GO;
            SHUF_GO:   state_d = SHUF_WAIT;
            SHUF_WAIT: if (shuffle_fin) state_d = DEC_GO;
            DEC_GO:    state_d = DEC_WAIT;
            DEC_WAIT: begin
                if (decrypt_fin) begin
                    state_d = NEXT;
                    pass_d  = decrypt_pass;
                end
            end
            NEXT: begin
                pass_d = 1'b0;
                if (pass_q) begin
                    state_d = DONE;
                    found_d = 1'b1;
                end else if (key_q == KEY_MAX) begin
                    // Exhausted: hold the last key rather than wrapping.
                    state_d = DONE;
                    found_d = 1'b0;
                end else begin
                    state_d = INIT_GO;
                    key_d   = key_q + 24'd1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = INIT_GO;
                    key_d   = KEY_START;
                    found_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            key_q           <= KEY_START;
            pass_q          <= 1'b0;
            found_q         <= 1'b0;
            init_start_q    <= 1'b0;
            shuffle_start_q <= 1'b0;
            decrypt_start_q <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            key_q           <= key_d;
            pass_q          <= pass_d;
            found_q         <= found_d;
            init_start_q    <= (state_d == INIT_GO);
            shuffle_start_q <= (state_d == SHUF_GO);
            decrypt_start_q <= (state_d == DEC_GO);
            done_q          <= (state_d == DONE);
            busy_q          <= (state_d != IDLE) && (state_d != DONE);
        end
    end

    always_comb begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
        case (state_q)
            INIT_GO, INIT_WAIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            SHUF_GO, SHUF_WAIT: begin
                s_addr = shuffle_addr;
                s_data = shuffle_data;
                s_wren = shuffle_wren;
            end
            DEC_GO, DEC_WAIT: begin
                s_addr = decrypt_addr;
                s_data = decrypt_data;
                s_wren = decrypt_wren;
            end
            default: ;
        endcase
        // Keep the memory quiet while reset is held, whatever state_q still says.
        if (!reset) begin
            s_addr = 8'h00;
            s_data = 8'h00;
            s_wren = 1'b0;
        end
    end

    assign init_start    = init_start_q;
    assign shuffle_start = shuffle_start_q;
    assign decrypt_start = decrypt_start_q;
    assign key           = key_q;
    assign done          = done_q;
    assign found         = found_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: two instances (default start key and a near-exhaustion start key)
// driven by a phase-FSM responder with random latencies, checked against a key-search model.
module tb_rc4_phase_ctrl;

    localparam logic [23:0] KS0 = 24'h000000;
    localparam logic [23:0] KS1 = 24'h3FFFFE;
    localparam logic [23:0] KM  = 24'h3FFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start0, start1;
    logic       init_fin, shuffle_fin, decrypt_fin, decrypt_pass;
    logic [7:0] init_addr, shuffle_addr, decrypt_addr, init_data, shuffle_data, decrypt_data;
    logic       init_wren, shuffle_wren, decrypt_wren;

    logic [1:0]       is_v, ss_v, ds_v, sw_v, dn_v, fd_v, bz_v;
    logic [1:0][7:0]  sa_v, sd_v;
    logic [1:0][23:0] ky_v;

    rc4_phase_ctrl #(.KEY_START(KS0), .KEY_MAX(KM)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .init_fin(init_fin), .shuffle_fin(shuffle_fin), .decrypt_fin(decrypt_fin),
        .decrypt_pass(decrypt_pass),
        .init_start(is_v[0]), .shuffle_start(ss_v[0]), .decrypt_start(ds_v[0]),
        .init_addr(init_addr), .shuffle_addr(shuffle_addr), .decrypt_addr(decrypt_addr),
        .init_data(init_data), .shuffle_data(shuffle_data), .decrypt_data(decrypt_data),
        .init_wren(init_wren), .shuffle_wren(shuffle_wren), .decrypt_wren(decrypt_wren),
        .s_addr(sa_v[0]), .s_data(sd_v[0]), .s_wren(sw_v[0]),
        .key(ky_v[0]), .done(dn_v[0]), .found(fd_v[0]), .busy(bz_v[0])
    );

    rc4_phase_ctrl #(.KEY_START(KS1), .KEY_MAX(KM)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .init_fin(init_fin), .shuffle_fin(shuffle_fin), .decrypt_fin(decrypt_fin),
        .decrypt_pass(decrypt_pass),
        .init_start(is_v[1]), .shuffle_start(ss_v[1]), .decrypt_start(ds_v[1]),
        .init_addr(init_addr), .shuffle_addr(shuffle_addr), .decrypt_addr(decrypt_addr),
        .init_data(init_data), .shuffle_data(shuffle_data), .decrypt_data(decrypt_data),
        .init_wren(init_wren), .shuffle_wren(shuffle_wren), .decrypt_wren(decrypt_wren),
        .s_addr(sa_v[1]), .s_data(sd_v[1]), .s_wren(sw_v[1]),
        .key(ky_v[1]), .done(dn_v[1]), .found(fd_v[1]), .busy(bz_v[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic fins_low();
        init_fin = 1'b0; shuffle_fin = 1'b0; decrypt_fin = 1'b0;
    endtask

    task automatic rand_sport();
        init_addr = 8'($urandom); shuffle_addr = 8'($urandom); decrypt_addr = 8'($urandom);
        init_data = 8'($urandom); shuffle_data = 8'($urandom); decrypt_data = 8'($urandom);
        init_wren = 1'($urandom); shuffle_wren = 1'($urandom); decrypt_wren = 1'($urandom);
    endtask

    // ph: 0 = nobody owns the port, 1 = init, 2 = shuffle, 3 = decrypt
    task automatic chk_sport(input int sel, input int ph);
        logic [7:0] ea, ed;
        logic       ew;
        ea = 8'h00; ed = 8'h00; ew = 1'b0;
        case (ph)
            1: begin ea = init_addr;    ed = init_data;    ew = init_wren;    end
            2: begin ea = shuffle_addr; ed = shuffle_data; ew = shuffle_wren; end
            3: begin ea = decrypt_addr; ed = decrypt_data; ew = decrypt_wren; end
            default: ;
        endcase
        chk("s_addr", sa_v[sel], ea);
        chk("s_data", sd_v[sel], ed);
        chk("s_wren", sw_v[sel], ew);
    endtask

    task automatic do_reset();
        reset = 1'b0; start0 = 1'b1; start1 = 1'b1;
        fins_low();
        init_wren = 1'b1; shuffle_wren = 1'b1; decrypt_wren = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_wren0", sw_v[0], 0);
        chk("rst_s_wren1", sw_v[1], 0);
        chk("rst_busy", bz_v[0], 0);
        chk("rst_done", dn_v[0], 0);
        chk("rst_found", fd_v[0], 0);
        chk("rst_key0", ky_v[0], KS0);
        chk("rst_key1", ky_v[1], KS1);
        chk("rst_starts", {is_v, ss_v, ds_v}, 0);
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", bz_v, 0);
        #1;
        chk("idle_s_wren", sw_v[0], 0);
        chk("idle_s_addr", sa_v[0], 0);
    endtask

    // Runs one full search on instance sel; the model predicts which keys get tried and the verdict.
    task automatic run_search(input int sel, input logic [23:0] ks, input logic [23:0] pkey,
                              input bit pvalid, input int lat, input bit hold);
        int          n_init, ph, cnt, exp_next, exp_tries;
        bit          fin_prev, got_done, seen;
        logic [23:0] mkey, exp_key;
        n_init = 0; ph = 0; cnt = 0; exp_next = 1; fin_prev = 0; got_done = 0;
        mkey = ks;
        set_start(sel, 1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!hold) set_start(sel, 1'b0);
            fins_low();
            if (fin_prev) ph = 0;
            fin_prev = 0;
            if (cyc == 0) begin
                chk("launch_done_clr", dn_v[sel], 0);
                chk("launch_found_clr", fd_v[sel], 0);
            end
            if (dn_v[sel]) begin
                got_done = 1;
                break;
            end
            chk("busy_run", bz_v[sel], 1);
            seen = 0;
            if (is_v[sel]) begin
                chk("order_init", exp_next, 1);
                ph = 1; n_init++; seen = 1; exp_next = 2;
                mkey = ks + 24'(n_init - 1);
                chk("key_tried", ky_v[sel], mkey);
            end
            if (ss_v[sel]) begin
                chk("order_shuf", exp_next, 2);
                ph = 2; seen = 1; exp_next = 3;
            end
            if (ds_v[sel]) begin
                chk("order_dec", exp_next, 3);
                ph = 3; seen = 1; exp_next = 1;
            end
            decrypt_pass = 1'($urandom);
            if (seen) begin
                cnt = (lat > 0) ? lat : int'($urandom_range(1, 4));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fin_prev = 1;
                    case (ph)
                        1: init_fin = 1'b1;
                        2: shuffle_fin = 1'b1;
                        3: begin
                            decrypt_fin = 1'b1;
                            decrypt_pass = pvalid && (mkey == pkey);
                        end
                        default: ;
                    endcase
                end
            end
            rand_sport();
            #1;
            chk_sport(sel, ph);
            chk_sport(1 - sel, 0);
        end
        chk("search_timeout", got_done, 1);
        exp_tries = pvalid ? int'(pkey - ks) + 1 : int'(KM - ks) + 1;
        exp_key   = pvalid ? pkey : KM;
        chk("tries", n_init, exp_tries);
        chk("final_key", ky_v[sel], exp_key);
        chk("found", fd_v[sel], pvalid);
        chk("busy_done", bz_v[sel], 0);
        if (hold) begin
            @(negedge clk);
            chk("hold_restart_init", is_v[sel], 1);
            chk("hold_restart_done", dn_v[sel], 0);
            chk("hold_restart_key", ky_v[sel], ks);
            set_start(sel, 1'b0);
        end
    endtask

    initial begin
        logic [23:0] pk;
        bit          pv;
        int          sel;
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; decrypt_pass = 1'b0;
        fins_low();
        rand_sport();
        do_reset();

        // Single-key search, fixed 3-cycle phase latency, first key passes.
        run_search(0, KS0, 24'h000000, 1, 3, 0);
        // Keys 0..4 fail, key 5 passes; restart from DONE.
        run_search(0, KS0, 24'h000005, 1, 0, 0);
        // Near-top start key, never passes: exhaustion without wrap.
        run_search(1, KS1, 24'h000000, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("done_hold_key", ky_v[1], KM);
            chk("done_hold_done", dn_v[1], 1);
            chk("done_hold_found", fd_v[1], 0);
        end

        // Fin strobes outside their own WAIT state must be ignored.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("go_init_start", is_v[0], 1);
        init_fin = 1'b1;
        @(negedge clk);
        init_fin = 1'b0;
        repeat (4) begin
            shuffle_fin = 1'b1; decrypt_fin = 1'b1;
            @(negedge clk);
            fins_low();
            chk("stray_no_shuf", ss_v[0], 0);
            chk("stray_no_init", is_v[0], 0);
            chk("stray_busy", bz_v[0], 1);
        end
        init_fin = 1'b1;
        @(negedge clk);
        init_fin = 1'b0;
        chk("real_fin_shuf", ss_v[0], 1);
        do_reset();

        // Reset mid-decrypt, then a stray decrypt_fin.
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; chk("a_init", is_v[0], 1);
        @(negedge clk); init_fin = 1'b1;
        @(negedge clk); init_fin = 1'b0; chk("a_shuf", ss_v[0], 1);
        @(negedge clk); shuffle_fin = 1'b1;
        @(negedge clk); shuffle_fin = 1'b0; chk("a_dec", ds_v[0], 1);
        @(negedge clk);
        init_wren = 1'b1; shuffle_wren = 1'b1; decrypt_wren = 1'b1; reset = 1'b0;
        #1;
        chk("rst_low_s_wren", sw_v[0], 0);
        @(negedge clk);
        chk("mid_rst_busy", bz_v[0], 0);
        chk("mid_rst_key", ky_v[0], KS0);
        chk("mid_rst_done", dn_v[0], 0);
        reset = 1'b1; decrypt_fin = 1'b1; decrypt_pass = 1'b1;
        @(negedge clk);
        fins_low();
        repeat (3) begin
            @(negedge clk);
            chk("stray_dec_idle", {bz_v[0], dn_v[0], is_v[0], ss_v[0], ds_v[0]}, 0);
        end

        // start held high across a whole search.
        run_search(0, KS0, 24'h000002, 1, 2, 1);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            if (sel == 0) begin
                pk = 24'($urandom_range(0, 4));
                pv = 1;
                run_search(0, KS0, pk, pv, 0, 0);
            end else begin
                pk = KS1 + 24'($urandom_range(0, 1));
                pv = 1'($urandom);
                run_search(1, KS1, pk, pv, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
